// File: rtl/eight_bit_down_counter.sv
// Loadable down counter with one-shot and auto-reload modes.
// Emits a registered terminal-count pulse and a busy flag.
module eight_bit_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] One  = WIDTH'(1);
  localparam logic [WIDTH-1:0] Zero = '0;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      count_q  <= Zero;
      reload_q <= Zero;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else if (load) begin
      // Load wins over enable, terminal count and mode; a zero load parks in idle.
      count_q  <= load_val;
      reload_q <= load_val;
      tc_q     <= 1'b0;
      if (load_val != Zero) begin
        state_q <= StRun;
        busy_q  <= 1'b1;
      end else begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (en) begin
            if (count_q > One) begin
              count_q <= count_q - One;
              tc_q    <= 1'b0;
            end else if (mode) begin
              count_q <= reload_q;
              tc_q    <= 1'b1;
            end else begin
              count_q <= Zero;
              tc_q    <= 1'b1;
              state_q <= StDone;
              busy_q  <= 1'b0;
            end
          end else begin
            tc_q <= 1'b0;
          end
        end
        StIdle, StDone: begin
          tc_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          tc_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Q    = count_q;
  assign tc   = tc_q;
  assign busy = busy_q;

endmodule
